demux_1to3_buf: RTL and testbench

//  Registered 1-to-3 demultiplexer: the write-side counterpart of the datapath 3:1 mux.

---
 rtl/demux_1to3_buf_pkg.sv | 27 ++
 rtl/demux_1to3_buf_if.sv | 58 +++++
 rtl/demux_1to3_buf_slot.sv | 62 ++++++
 rtl/demux_1to3_buf.sv | 78 +++++++
 tb/tb_demux_1to3_buf.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/demux_1to3_buf_pkg.sv
// Shared types and constants for the registered 1-to-3 demultiplexer.
// Optional transfer counters are enabled with the DEMUX_COUNT_EN macro.
package lc3_demux_pkg;

    typedef enum logic [1:0] {
        SEL_D0  = 2'b00,
        SEL_D1  = 2'b01,
        SEL_D2  = 2'b10,
        SEL_BAD = 2'b11
    } sel_t;

    localparam int NUM_CH = 3;

    // One-hot channel decode of a destination select; the illegal code maps to no channel.
    function automatic logic [NUM_CH-1:0] sel_decode(input sel_t sel);
        logic [NUM_CH-1:0] onehot;
        onehot = '0;
        case (sel)
            SEL_D0:  onehot = 3'b001;
            SEL_D1:  onehot = 3'b010;
            SEL_D2:  onehot = 3'b100;
            SEL_BAD: onehot = 3'b000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/demux_1to3_buf_if.sv
// Handshake bundle between the LC-3 bus driver, the demux and its three consumers.
// With DEMUX_COUNT_EN defined the bundle also carries the per-channel transfer counters.
interface demux_1to3_buf_if #(
    parameter int WIDTH = 16
`ifdef DEMUX_COUNT_EN
    , parameter int CNT_W = 8
`endif
);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       select;
    logic [WIDTH-1:0] D_in;

    logic             D0_valid;
    logic             D1_valid;
    logic             D2_valid;
    logic             D0_ready;
    logic             D1_ready;
    logic             D2_ready;
    logic [WIDTH-1:0] D0_out;
    logic [WIDTH-1:0] D1_out;
    logic [WIDTH-1:0] D2_out;
    logic             sel_err;

`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] D0_cnt;
    logic [CNT_W-1:0] D1_cnt;
    logic [CNT_W-1:0] D2_cnt;

    // Producer and consumers side.
    modport master (
        output in_valid, select, D_in, D0_ready, D1_ready, D2_ready,
        input  in_ready, D0_valid, D1_valid, D2_valid, D0_out, D1_out, D2_out, sel_err,
        input  D0_cnt, D1_cnt, D2_cnt
    );

    // Demux side.
    modport slave (
        input  in_valid, select, D_in, D0_ready, D1_ready, D2_ready,
        output in_ready, D0_valid, D1_valid, D2_valid, D0_out, D1_out, D2_out, sel_err,
        output D0_cnt, D1_cnt, D2_cnt
    );
`else
    // Producer and consumers side.
    modport master (
        output in_valid, select, D_in, D0_ready, D1_ready, D2_ready,
        input  in_ready, D0_valid, D1_valid, D2_valid, D0_out, D1_out, D2_out, sel_err
    );

    // Demux side.
    modport slave (
        input  in_valid, select, D_in, D0_ready, D1_ready, D2_ready,
        output in_ready, D0_valid, D1_valid, D2_valid, D0_out, D1_out, D2_out, sel_err
    );
`endif

endinterface

// File: rtl/demux_1to3_buf_slot.sv
// demux_slot: one-entry output buffer for a single demux channel.
// A write and a drain on the same edge replace the word with no bubble.
// With DEMUX_COUNT_EN defined it also counts output transfers (wrapping).
module demux_slot #(
    parameter int WIDTH = 16
`ifdef DEMUX_COUNT_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             full,
    output logic             ready,
    output logic [WIDTH-1:0] data
`ifdef DEMUX_COUNT_EN
    , output logic [CNT_W-1:0] cnt
`endif
);

    logic rd_xfer;

    assign rd_xfer = full & rd_ready;
    // The slot can take a word when empty or when its current word leaves this cycle.
    assign ready   = ~full | rd_ready;

    // Occupancy flag: a write wins over a same-edge drain so the slot stays full.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            full <= 1'b0;
        end else if (wr_en) begin
            full <= 1'b1;
        end else if (rd_xfer) begin
            full <= 1'b0;
        end
    end

    // Data register: captures accepted words and holds its value otherwise, even after a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this datapath register is reset on purpose because its value is visible on the port after reset.
        if (!rst_n) begin
            data <= '0;
        end else if (wr_en) begin
            data <= wr_data;
        end
    end

`ifdef DEMUX_COUNT_EN
    // Transfer counter: one step per word taken by the consumer, wrapping at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rd_xfer) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux_1to3_buf.sv
// demux_1to3_buf: registered 1-to-3 demultiplexer with one-entry buffers per channel.
// Routes a valid/ready input word to D0/D1/D2 by select; select 11 drops the word and
// pulses sel_err. Per-channel transfer counters are added when DEMUX_COUNT_EN is defined.
module demux_1to3_buf
    import lc3_demux_pkg::*;
#(
    parameter int WIDTH = 16
`ifdef DEMUX_COUNT_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic           Clk,
    input  logic           Reset_n,
    demux_1to3_buf_if.slave bus
);

    sel_t              sel;
    logic [NUM_CH-1:0] sel_onehot;
    logic [NUM_CH-1:0] wr_en;
    logic [NUM_CH-1:0] rd_ready;
    logic [NUM_CH-1:0] slot_full;
    logic [NUM_CH-1:0] slot_ready;
    logic [WIDTH-1:0]  slot_data [NUM_CH];
`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0]  slot_cnt  [NUM_CH];
`endif

    assign sel        = sel_t'(bus.select);
    assign sel_onehot = sel_decode(sel);
    assign rd_ready   = {bus.D2_ready, bus.D1_ready, bus.D0_ready};

    // Only the selected channel's readiness matters; illegal selects are always consumed.
    assign bus.in_ready = (sel == SEL_BAD) | (|(sel_onehot & slot_ready));
    assign wr_en        = sel_onehot & slot_ready & {NUM_CH{bus.in_valid}};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
`ifdef DEMUX_COUNT_EN
            , .CNT_W (CNT_W)
`endif
        ) u_slot (
            .clk      (Clk),
            .rst_n    (Reset_n),
            .wr_en    (wr_en[i]),
            .wr_data  (bus.D_in),
            .rd_ready (rd_ready[i]),
            .full     (slot_full[i]),
            .ready    (slot_ready[i]),
            .data     (slot_data[i])
`ifdef DEMUX_COUNT_EN
            , .cnt    (slot_cnt[i])
`endif
        );
    end

    assign bus.D0_valid = slot_full[0];
    assign bus.D1_valid = slot_full[1];
    assign bus.D2_valid = slot_full[2];
    assign bus.D0_out   = slot_data[0];
    assign bus.D1_out   = slot_data[1];
    assign bus.D2_out   = slot_data[2];
`ifdef DEMUX_COUNT_EN
    assign bus.D0_cnt   = slot_cnt[0];
    assign bus.D1_cnt   = slot_cnt[1];
    assign bus.D2_cnt   = slot_cnt[2];
`endif

    // Error pulse: high for exactly the cycle after an illegal-select word is consumed.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.sel_err <= 1'b0;
        end else begin
            bus.sel_err <= bus.in_valid & (sel == SEL_BAD);
        end
    end

endmodule

// File: tb/tb_demux_1to3_buf.sv
// Self-checking bench for demux_1to3_buf: directed scenarios followed by random traffic,
// all compared against a per-channel occupancy model. Counter checks with DEMUX_COUNT_EN.
module tb_demux_1to3_buf;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

`ifdef DEMUX_COUNT_EN
    demux_1to3_buf_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
    demux_1to3_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );
`else
    demux_1to3_buf_if #(.WIDTH(WIDTH)) bus ();
    demux_1to3_buf #(.WIDTH(WIDTH)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );
`endif

    int total = 0;
    int bad   = 0;

    // Model: what each channel currently holds, how many words it has delivered, and the error pulse.
    bit               m_full [3];
    logic [WIDTH-1:0] m_word [3];
    int               m_cnt  [3];
    bit               m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic dut_valid(input int ch);
        case (ch)
            0:       return bus.D0_valid;
            1:       return bus.D1_valid;
            default: return bus.D2_valid;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] dut_out(input int ch);
        case (ch)
            0:       return bus.D0_out;
            1:       return bus.D1_out;
            default: return bus.D2_out;
        endcase
    endfunction

`ifdef DEMUX_COUNT_EN
    function automatic logic [CNT_W-1:0] dut_cnt(input int ch);
        case (ch)
            0:       return bus.D0_cnt;
            1:       return bus.D1_cnt;
            default: return bus.D2_cnt;
        endcase
    endfunction
`endif

    task automatic model_reset();
        for (int ch = 0; ch < 3; ch++) begin
            m_full[ch] = 1'b0;
            m_word[ch] = '0;
            m_cnt[ch]  = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        for (int ch = 0; ch < 3; ch++) begin
            check($sformatf("%s.D%0d_valid", tag, ch), 32'(dut_valid(ch)), 32'(m_full[ch]));
            check($sformatf("%s.D%0d_out", tag, ch), 32'(dut_out(ch)), 32'(m_word[ch]));
`ifdef DEMUX_COUNT_EN
            check($sformatf("%s.D%0d_cnt", tag, ch), 32'(dut_cnt(ch)), 32'(m_cnt[ch] % (1 << CNT_W)));
`endif
        end
        check($sformatf("%s.sel_err", tag), 32'(bus.sel_err), 32'(m_err));
    endtask

    task automatic drive(input bit v, input logic [1:0] s, input logic [WIDTH-1:0] d, input logic [2:0] rdy);
        bus.in_valid = v;
        bus.select   = s;
        bus.D_in     = d;
        bus.D0_ready = rdy[0];
        bus.D1_ready = rdy[1];
        bus.D2_ready = rdy[2];
    endtask

    // One clock cycle starting at a falling edge: apply inputs, check in_ready, predict, clock, check outputs.
    task automatic step(input bit v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                        input logic [2:0] rdy, input string tag);
        int idx;
        bit exp_ready;
        idx = int'(s);
        drive(v, s, d, rdy);
        #1;
        exp_ready = (idx == 3) ? 1'b1 : (!m_full[idx] || rdy[idx]);
        check($sformatf("%s.in_ready", tag), 32'(bus.in_ready), 32'(exp_ready));
        for (int ch = 0; ch < 3; ch++) begin
            if (m_full[ch] && rdy[ch]) begin
                m_full[ch] = 1'b0;
                m_cnt[ch]  = m_cnt[ch] + 1;
            end
        end
        if (v && idx != 3 && exp_ready) begin
            m_full[idx] = 1'b1;
            m_word[idx] = d;
        end
        m_err = v && (idx == 3);
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        drive(1'b0, 2'b00, '0, 3'b000);

        // 1. Reset held with random inputs, then release with the input idle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'($urandom), 2'($urandom), 16'($urandom), 3'($urandom));
        end
        #1;
        check_outputs("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'($urandom), 16'($urandom), 3'($urandom), "reset_idle");
        end

        // 2. Route one word to each channel with all consumers stalled; a further D0 word is refused.
        step(1'b1, 2'b00, 16'hAAAA, 3'b000, "route_d0");
        step(1'b1, 2'b01, 16'h5555, 3'b000, "route_d1");
        step(1'b1, 2'b10, 16'h1234, 3'b000, "route_d2");
        step(1'b1, 2'b00, 16'h9999, 3'b000, "route_d0_stall");

        // 3. Stream four words into D1 while its consumer drains every cycle.
        step(1'b1, 2'b01, 16'h1111, 3'b010, "stream0");
        step(1'b1, 2'b01, 16'h2222, 3'b010, "stream1");
        step(1'b1, 2'b01, 16'h3333, 3'b010, "stream2");
        step(1'b1, 2'b01, 16'h4444, 3'b010, "stream3");
        step(1'b0, 2'b01, 16'h0000, 3'b010, "stream_drain");

        // 4. Illegal select: consumed and dropped, error pulse for one cycle only.
        step(1'b1, 2'b11, 16'hDEAD, 3'b000, "illegal");
        step(1'b0, 2'b11, 16'hDEAD, 3'b000, "illegal_after");

        // 5. Load BEEF into D2 (replacing 1234 on a drain edge), then reset asynchronously.
        step(1'b1, 2'b10, 16'hBEEF, 3'b100, "beef_load");
        drive(1'b0, 2'b00, '0, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst.D2_valid", 32'(bus.D2_valid), 32'd0);
        check("async_rst.D2_out", 32'(bus.D2_out), 32'd0);
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 6. 257 transfers through D0 with the consumer always ready.
        for (int i = 0; i < 257; i++) begin
            step(1'b1, 2'b00, 16'(i), 3'b001, "d0_burst");
        end
        step(1'b0, 2'b00, '0, 3'b001, "d0_burst_drain");
`ifdef DEMUX_COUNT_EN
        check("wrap.D0_cnt", 32'(bus.D0_cnt), 32'd1);
        check("wrap.D1_cnt", 32'(bus.D1_cnt), 32'd0);
        check("wrap.D2_cnt", 32'(bus.D2_cnt), 32'd0);
`endif

        // Random traffic with independent, randomly stalling consumers.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 16'($urandom),
                 3'($urandom), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
